frame_buf_mgr: RTL and testbench
================================

Name: frame_buf_mgr

Overview:
- Parametrised multi-channel frame-buffer address manager for the SDRAM 4-port controller path. Successor to the fixed dual-channel ping-pong selector.
- Each channel owns NUM_BUF frame slots in SDRAM. The writer always targets a slot the reader is not using. The reader latches the newest complete frame at its own frame boundary.
- Supports 2-buffer ping-pong (legacy, tearing possible) and 3/4-buffer tear-free mode. Drives WRx_ADDR/WRx_MAX_ADDR/RDx_ADDR/RDx_MAX_ADDR of the SDRAM port controller.

Parameters:
- NUM_CH, 2, number of independent write/read channel pairs (1..4).
- NUM_BUF, 3, frame slots per channel (2..4).
- FRAME_LEN, 307200, words per frame (640*480).
- ADDR_W, 24, SDRAM word-address width.
- BASE_ADDR, 0, first word address of channel 0, slot 0.

Ports:
- clk  in  1  system/SDRAM controller clock.
- rst  in  1  synchronous reset, active-high.
- wr_finish  in  NUM_CH  one-cycle pulse per channel: writer completed a frame.
- rd_finish  in  NUM_CH  one-cycle pulse per channel: reader completed a frame.
- wr_addr  out  NUM_CH*ADDR_W  write slot start address; channel c at bits [c*ADDR_W +: ADDR_W].
- wr_max_addr  out  NUM_CH*ADDR_W  write slot end address (exclusive).
- rd_addr  out  NUM_CH*ADDR_W  read slot start address.
- rd_max_addr  out  NUM_CH*ADDR_W  read slot end address (exclusive).
- rd_valid  out  NUM_CH  reader holds at least one complete frame.
- tear  out  NUM_CH  one-cycle pulse: writer entered the slot currently being read (NUM_BUF=2 only).
- drop_cnt  out  NUM_CH*8  per-channel saturating count of completed frames overwritten before being read.

Behaviour:
- Per-channel state: w (write slot), l (latest complete slot), r (read slot), nf (new-frame-pending flag), v (rd_valid). All channels are independent and use identical logic.
- Slot address = BASE_ADDR + (c*NUM_BUF + idx)*FRAME_LEN. Max address = slot address + FRAME_LEN. Evaluate at ADDR_W width. Constant multiply only; no runtime multiplier.
- All outputs are registered and are driven from the indices. An address change is visible 1 cycle after the triggering pulse.
- Reset (any time, including mid-frame) sets:
  - w=0, l=0, r=NUM_BUF-1, nf=0, v=0, drop_cnt=0, tear=0.
  - Addresses reflect these indices in the cycle after rst deasserts.
- Next-write rule: w' = lowest index not equal to r' and not equal to l'.
  - For NUM_BUF>=3 such an index always exists.
  - For NUM_BUF=2: w' = the index other than l'. If w'==r', pulse tear.
- wr_finish only: l'=w, nf'=1, r unchanged. If nf was already 1, increment drop_cnt (saturate at 255).
- rd_finish only:
  - If nf=1: r'=l, nf'=0, v'=1.
  - Else: r unchanged; the reader repeats the last frame. v unchanged, w unchanged.
- wr_finish and rd_finish in the same cycle: r'=w (old), l'=w (old), nf'=0, v'=1, w' per next-write rule. drop_cnt is not incremented.
- Neither pulse: hold all state.
- Pulses wider than 1 cycle are treated as repeated events. The upstream port controller guarantees single-cycle pulses.
- Synthesis-time check: NUM_BUF outside 2..4 or NUM_CH outside 1..4 must fail elaboration.
- Address overflow (base + NUM_CH*NUM_BUF*FRAME_LEN > 2^ADDR_W) must fail elaboration.

Test Plan:
All scenarios use NUM_CH=2, NUM_BUF=3, FRAME_LEN=100, BASE_ADDR=0 unless stated.
1. Reset:
   - ch0: wr_addr=0, wr_max=100, rd_addr=200, rd_max=300, rd_valid=0.
   - ch1: wr_addr=300, rd_addr=500.
   - drop_cnt=0.
2. Single frame (ch0): wr_finish pulse → next cycle wr_addr=100. rd unchanged at 200. Then rd_finish → rd_addr=0, rd_max=100, rd_valid=1.
3. Drop (ch0, from reset): two wr_finish pulses with no rd_finish → wr_addr=100 then 0; drop_cnt=1. rd_finish → rd_addr=100. A further rd_finish with no new frame leaves rd_addr=100.
4. Simultaneous (ch0 state w=1, l=0, nf=1, r=2): wr_finish and rd_finish in the same cycle → rd_addr=100, wr_addr=0, drop_cnt unchanged. ch1 outputs unaffected throughout.
5. Ping-pong (NUM_BUF=2):
   - Reset: wr_addr=0, rd_addr=100.
   - wr_finish: wr_addr=100 with tear pulse (reader still on slot 1).
   - rd_finish: rd_addr=0.
6. Reset mid-operation: assert rst for 1 cycle after scenario 3 → all outputs return to reset values, drop_cnt=0. A wr_finish asserted during the rst cycle is ignored.

Source files
------------

// File: rtl/frame_buf_mgr.sv
// Multi-channel frame-buffer slot manager: picks the SDRAM write and read slots for
// each channel so the writer never targets the slot that the reader is scanning.
module frame_buf_mgr #(
  parameter int NUM_CH    = 2,
  parameter int NUM_BUF   = 3,
  parameter int FRAME_LEN = 307200,
  parameter int ADDR_W    = 24,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_finish,
  input  logic [NUM_CH-1:0]        rd_finish,
  output logic [NUM_CH*ADDR_W-1:0] wr_addr,
  output logic [NUM_CH*ADDR_W-1:0] wr_max_addr,
  output logic [NUM_CH*ADDR_W-1:0] rd_addr,
  output logic [NUM_CH*ADDR_W-1:0] rd_max_addr,
  output logic [NUM_CH-1:0]        rd_valid,
  output logic [NUM_CH-1:0]        tear,
  output logic [NUM_CH*8-1:0]      drop_cnt
);

  typedef logic [1:0] idx_t;

  localparam idx_t   LAST_IDX = idx_t'(NUM_BUF - 1);
  localparam longint END_ADDR = longint'(BASE_ADDR) +
                                longint'(NUM_CH) * longint'(NUM_BUF) * longint'(FRAME_LEN);

  if (NUM_BUF < 2 || NUM_BUF > 4) begin : g_bad_num_buf
    $error("frame_buf_mgr: NUM_BUF must be in 2..4");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("frame_buf_mgr: NUM_CH must be in 1..4");
  end
  if (END_ADDR > (longint'(1) << ADDR_W)) begin : g_addr_overflow
    $error("frame_buf_mgr: frame slots do not fit in ADDR_W address space");
  end

  // Only ever called with elaboration constants, so each table entry folds to a constant.
  function automatic logic [ADDR_W-1:0] slot_base(input int ch, input int idx);
    longint a;
    a = longint'(BASE_ADDR) +
        (longint'(ch) * longint'(NUM_BUF) + longint'(idx)) * longint'(FRAME_LEN);
    return ADDR_W'(a);
  endfunction

  // Lowest slot that is neither being read nor holding the latest complete frame.
  // With two slots there is no free one, so the writer takes whichever is not latest.
  function automatic idx_t next_write(input idx_t r, input idx_t l);
    idx_t w;
    w = '0;
    if (NUM_BUF == 2) begin
      w = {1'b0, ~l[0]};
    end else begin
      for (int i = NUM_BUF - 1; i >= 0; i--) begin
        if (idx_t'(i) != r && idx_t'(i) != l) w = idx_t'(i);
      end
    end
    return w;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ADDR_W-1:0] start_tbl [4];
    logic [ADDR_W-1:0] end_tbl   [4];

    for (genvar k = 0; k < 4; k++) begin : g_tbl
      assign start_tbl[k] = slot_base(c, k);
      assign end_tbl[k]   = slot_base(c, k + 1);
    end

    idx_t              w_q, l_q, r_q, w_d, l_d, r_d;
    logic              nf_q, v_q, tear_q, nf_d, v_d, tear_d;
    logic [7:0]        drop_q, drop_d;
    logic [ADDR_W-1:0] wa_q, wm_q, ra_q, rm_q;

    always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      w_d    = w_q;
      l_d    = l_q;
      r_d    = r_q;
      nf_d   = nf_q;
      v_d    = v_q;
      drop_d = drop_q;
      tear_d = 1'b0;

      case ({wr_finish[c], rd_finish[c]})
        2'b10: begin
          l_d  = w_q;
          nf_d = 1'b1;
          if (nf_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
        2'b01: begin
          if (nf_q) begin
            r_d  = l_q;
            nf_d = 1'b0;
            v_d  = 1'b1;
          end
        end
        2'b11: begin
          // Reader takes the frame that just completed; nothing is lost.
          r_d  = w_q;
          l_d  = w_q;
          nf_d = 1'b0;
          v_d  = 1'b1;
        end
        default: ;
      endcase

      if (wr_finish[c]) begin
        w_d = next_write(r_d, l_d);
        if (NUM_BUF == 2 && w_d == r_d) tear_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order.
      if (rst) begin
        w_q    <= '0;
        l_q    <= '0;
        r_q    <= LAST_IDX;
        nf_q   <= 1'b0;
        v_q    <= 1'b0;
        tear_q <= 1'b0;
        drop_q <= '0;
        wa_q   <= start_tbl[0];
        wm_q   <= end_tbl[0];
        ra_q   <= start_tbl[LAST_IDX];
        rm_q   <= end_tbl[LAST_IDX];
      end else begin
        w_q    <= w_d;
        l_q    <= l_d;
        r_q    <= r_d;
        nf_q   <= nf_d;
        v_q    <= v_d;
        tear_q <= tear_d;
        drop_q <= drop_d;
        wa_q   <= start_tbl[w_d];
        wm_q   <= end_tbl[w_d];
        ra_q   <= start_tbl[r_d];
        rm_q   <= end_tbl[r_d];
      end
    end

    assign wr_addr[c*ADDR_W +: ADDR_W]     = wa_q;
    assign wr_max_addr[c*ADDR_W +: ADDR_W] = wm_q;
    assign rd_addr[c*ADDR_W +: ADDR_W]     = ra_q;
    assign rd_max_addr[c*ADDR_W +: ADDR_W] = rm_q;
    assign rd_valid[c]                     = v_q;
    assign tear[c]                         = tear_q;
    assign drop_cnt[c*8 +: 8]              = drop_q;
  end

endmodule

// File: tb/tb_frame_buf_mgr.sv
// Scoreboard bench for frame_buf_mgr: a 2-channel triple-buffer instance and a
// 1-channel ping-pong instance, both with FRAME_LEN=100.
module tb_frame_buf_mgr;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr3, rd3;
  logic [0:0]  wr2, rd2;
  logic [47:0] wa3, wm3, ra3, rm3;
  logic [1:0]  val3, tear3;
  logic [15:0] drop3;
  logic [23:0] wa2, wm2, ra2, rm2;
  logic [0:0]  val2, tear2;
  logic [7:0]  drop2;

  always #5 clk = ~clk;

  frame_buf_mgr #(.NUM_CH(2), .NUM_BUF(3), .FRAME_LEN(100), .ADDR_W(24), .BASE_ADDR(0)) u3 (
    .clk(clk), .rst(rst), .wr_finish(wr3), .rd_finish(rd3),
    .wr_addr(wa3), .wr_max_addr(wm3), .rd_addr(ra3), .rd_max_addr(rm3),
    .rd_valid(val3), .tear(tear3), .drop_cnt(drop3)
  );

  frame_buf_mgr #(.NUM_CH(1), .NUM_BUF(2), .FRAME_LEN(100), .ADDR_W(24), .BASE_ADDR(0)) u2 (
    .clk(clk), .rst(rst), .wr_finish(wr2), .rd_finish(rd2),
    .wr_addr(wa2), .wr_max_addr(wm2), .rd_addr(ra2), .rd_max_addr(rm2),
    .rd_valid(val2), .tear(tear2), .drop_cnt(drop2)
  );

  typedef enum {S_WR, S_WRM, S_RD, S_RDM, S_VAL, S_TEAR, S_DROP} sig_e;
  typedef struct {
    int     cyc;
    int     dut;
    int     ch;
    sig_e   sig;
    longint exp;
    string  name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint actual(input int dut, input int ch, input sig_e s);
    longint v;
    v = -1;
    if (dut == 0) begin
      case (s)
        S_WR:   v = longint'(wa3[ch*24 +: 24]);
        S_WRM:  v = longint'(wm3[ch*24 +: 24]);
        S_RD:   v = longint'(ra3[ch*24 +: 24]);
        S_RDM:  v = longint'(rm3[ch*24 +: 24]);
        S_VAL:  v = longint'(val3[ch]);
        S_TEAR: v = longint'(tear3[ch]);
        S_DROP: v = longint'(drop3[ch*8 +: 8]);
        default: v = -1;
      endcase
    end else begin
      case (s)
        S_WR:   v = longint'(wa2);
        S_WRM:  v = longint'(wm2);
        S_RD:   v = longint'(ra2);
        S_RDM:  v = longint'(rm2);
        S_VAL:  v = longint'(val2[0]);
        S_TEAR: v = longint'(tear2[0]);
        S_DROP: v = longint'(drop2);
        default: v = -1;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Queue an expectation that must hold dly clock edges from now.
  task automatic expect_v(input int dly, input int dut, input int ch, input sig_e s,
                          input longint v, input string name);
    exp_t x;
    x.cyc  = cyc + dly;
    x.dut  = dut;
    x.ch   = ch;
    x.sig  = s;
    x.exp  = v;
    x.name = name;
    sb.push_back(x);
  endtask

  // Monitor: compares every expectation whose cycle has arrived, away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else begin
        check(e.name, actual(e.dut, e.ch, e.sig), e.exp);
      end
    end
  end

  // Called on a negedge: holds the pulses across exactly one rising edge.
  task automatic drive(input logic [1:0] w3, input logic [1:0] r3,
                       input logic w2b, input logic r2b);
    wr3 = w3;
    rd3 = r3;
    wr2 = w2b;
    rd2 = r2b;
    @(negedge clk);
    wr3 = '0;
    rd3 = '0;
    wr2 = '0;
    rd2 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr3 = '0;
    rd3 = '0;
    wr2 = '0;
    rd2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state of both instances
    expect_v(1, 0, 0, S_WR,   0,   "rst_ch0_wr");
    expect_v(1, 0, 0, S_WRM,  100, "rst_ch0_wrmax");
    expect_v(1, 0, 0, S_RD,   200, "rst_ch0_rd");
    expect_v(1, 0, 0, S_RDM,  300, "rst_ch0_rdmax");
    expect_v(1, 0, 0, S_VAL,  0,   "rst_ch0_valid");
    expect_v(1, 0, 0, S_DROP, 0,   "rst_ch0_drop");
    expect_v(1, 0, 1, S_WR,   300, "rst_ch1_wr");
    expect_v(1, 0, 1, S_RD,   500, "rst_ch1_rd");
    expect_v(1, 0, 1, S_DROP, 0,   "rst_ch1_drop");
    expect_v(1, 1, 0, S_WR,   0,   "pp_rst_wr");
    expect_v(1, 1, 0, S_RD,   100, "pp_rst_rd");
    @(negedge clk);

    // Single frame on ch0
    expect_v(1, 0, 0, S_WR,   100, "single_wr");
    expect_v(1, 0, 0, S_RD,   200, "single_rd_hold");
    expect_v(1, 0, 0, S_TEAR, 0,   "single_no_tear");
    expect_v(1, 0, 1, S_WR,   300, "single_ch1_wr");
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    expect_v(1, 0, 0, S_RD,   0,   "single_rd");
    expect_v(1, 0, 0, S_RDM,  100, "single_rdmax");
    expect_v(1, 0, 0, S_VAL,  1,   "single_valid");
    expect_v(1, 0, 0, S_WR,   100, "single_wr_kept");
    drive(2'b00, 2'b01, 1'b0, 1'b0);

    // Ping-pong instance: writer moves onto the slot still being read
    expect_v(1, 1, 0, S_WR,   100, "pp_wr");
    expect_v(1, 1, 0, S_TEAR, 1,   "pp_tear_pulse");
    expect_v(1, 1, 0, S_RD,   100, "pp_rd_hold");
    expect_v(2, 1, 0, S_TEAR, 0,   "pp_tear_end");
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    expect_v(1, 1, 0, S_RD,   0,   "pp_rd");
    expect_v(1, 1, 0, S_RDM,  100, "pp_rdmax");
    expect_v(1, 1, 0, S_VAL,  1,   "pp_valid");
    drive(2'b00, 2'b00, 1'b0, 1'b1);

    // Clean restart, then drop scenario on ch0
    rst = 1'b1;
    expect_v(1, 0, 0, S_RD, 200, "rst2_ch0_rd");
    @(negedge clk);
    rst = 1'b0;
    expect_v(1, 0, 0, S_WR,   100, "drop_wr1");
    expect_v(1, 0, 0, S_DROP, 0,   "drop_cnt0");
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    expect_v(1, 0, 0, S_WR,   0,   "drop_wr2");
    expect_v(1, 0, 0, S_WRM,  100, "drop_wrmax2");
    expect_v(1, 0, 0, S_DROP, 1,   "drop_cnt1");
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    expect_v(1, 0, 0, S_RD,   100, "drop_rd");
    expect_v(1, 0, 0, S_RDM,  200, "drop_rdmax");
    expect_v(1, 0, 0, S_VAL,  1,   "drop_valid");
    drive(2'b00, 2'b01, 1'b0, 1'b0);
    expect_v(1, 0, 0, S_RD,   100, "repeat_rd");
    expect_v(1, 0, 0, S_WR,   0,   "repeat_wr");
    drive(2'b00, 2'b01, 1'b0, 1'b0);

    // Reset mid-operation with a coincident wr_finish that must be ignored
    rst = 1'b1;
    wr3 = 2'b01;
    expect_v(1, 0, 0, S_WR,   0,   "mid_rst_wr");
    expect_v(1, 0, 0, S_WRM,  100, "mid_rst_wrmax");
    expect_v(1, 0, 0, S_RD,   200, "mid_rst_rd");
    expect_v(1, 0, 0, S_RDM,  300, "mid_rst_rdmax");
    expect_v(1, 0, 0, S_VAL,  0,   "mid_rst_valid");
    expect_v(1, 0, 0, S_DROP, 0,   "mid_rst_drop");
    expect_v(1, 0, 1, S_RD,   500, "mid_rst_ch1_rd");
    expect_v(1, 1, 0, S_RD,   100, "mid_rst_pp_rd");
    expect_v(1, 1, 0, S_VAL,  0,   "mid_rst_pp_valid");
    @(negedge clk);
    rst = 1'b0;
    wr3 = '0;
    expect_v(1, 0, 0, S_WR,   0,   "post_rst_wr");
    expect_v(1, 0, 0, S_DROP, 0,   "post_rst_drop");
    @(negedge clk);

    // Simultaneous finish from w=1,l=0,nf=1,r=2
    expect_v(1, 0, 0, S_WR,   100, "sim_setup_wr");
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    expect_v(1, 0, 0, S_RD,   100, "sim_rd");
    expect_v(1, 0, 0, S_RDM,  200, "sim_rdmax");
    expect_v(1, 0, 0, S_WR,   0,   "sim_wr");
    expect_v(1, 0, 0, S_DROP, 0,   "sim_drop");
    expect_v(1, 0, 0, S_VAL,  1,   "sim_valid");
    expect_v(1, 0, 1, S_WR,   300, "sim_ch1_wr");
    expect_v(1, 0, 1, S_RD,   500, "sim_ch1_rd");
    expect_v(1, 0, 1, S_VAL,  0,   "sim_ch1_valid");
    expect_v(1, 0, 1, S_DROP, 0,   "sim_ch1_drop");
    drive(2'b01, 2'b01, 1'b0, 1'b0);

    // Drop counter saturation on ch1: first write sets pending, later ones each drop
    for (int i = 1; i <= 260; i++) begin
      if (i == 255) expect_v(1, 0, 1, S_DROP, 254, "sat_drop_254");
      if (i == 256) expect_v(1, 0, 1, S_DROP, 255, "sat_drop_255");
      if (i == 260) begin
        expect_v(1, 0, 1, S_DROP, 255, "sat_drop_hold");
        expect_v(1, 0, 1, S_WR,   300, "sat_ch1_wr");
        expect_v(1, 0, 0, S_DROP, 0,   "sat_ch0_drop");
      end
      drive(2'b10, 2'b00, 1'b0, 1'b0);
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never sampled, due cycle %0d", e.name, e.cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
